// File: rtl/fetch_pc_gen.sv
// Front-end fetch PC generator: holds the fetch PC, offers it over valid/ready,
// advances by 4 through a ripple adder and accepts backend redirects.
// Optional build macro: FETCH_PC_MISALIGN_TRAP_EN (misaligned redirects trap).

module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];
endmodule

module fetch_pc_gen #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             pc_ready,
    output logic             pc_valid,
    output logic [XLEN-1:0]  pc_out,
    output logic [CNT_W-1:0] fetch_count,
    output logic             misalign
);
`ifdef FETCH_PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, TRAP} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
`endif

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t           state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  redirect_tgt;
    logic             fire;
    logic             unused_cout;

    adder #(.WIDTH(XLEN)) u_pc_inc (
        .a    (pc_reg),
        .b    (PC_STEP),
        .cin  (1'b0),
        .sum  (pc_plus4),
        .cout (unused_cout)
    );

`ifdef FETCH_PC_MISALIGN_TRAP_EN
    // Target kept verbatim so the trap handler sees the faulting address.
    logic redirect_bad;
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = |redirect_pc[1:0];
    assign misalign     = (state_reg == TRAP);
`else
    logic unused_lsbs;
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_lsbs  = ^redirect_pc[1:0];
    assign misalign     = 1'b0;
`endif

    assign fire = (state_reg == RUN) && pc_ready;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;

        // A handshake in the redirect cycle still counts: fetch already took it.
        if (fire) begin
            count_next = count_reg + CNT_W'(1);
        end

        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     if (fire) pc_next = pc_plus4;
            FLUSH:   state_next = RUN;
`ifdef FETCH_PC_MISALIGN_TRAP_EN
            TRAP:    state_next = TRAP;
`endif
            default: state_next = BOOT;
        endcase

        if (redirect_valid) begin
            pc_next = redirect_tgt;
`ifdef FETCH_PC_MISALIGN_TRAP_EN
            state_next = redirect_bad ? TRAP : FLUSH;
`else
            state_next = FLUSH;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    assign pc_valid    = (state_reg == RUN);
    assign pc_out      = pc_reg;
    assign fetch_count = count_reg;
endmodule
